// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the byte producers, the TX FIFO and the UART transmitter.
// The FIFO takes the slave modport; the producer/transmitter side takes master.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW:0]   count;
  logic          empty;
  logic          overflow;

  modport slave (
    input  wr_valid, wr_data, tx_ready,
    output wr_ready, tx_data, tx_valid, count, empty, overflow
  );

  modport master (
    output wr_valid, wr_data, tx_ready,
    input  wr_ready, tx_data, tx_valid, count, empty, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with a drain sequencer that replays bytes to a raise-valid / wait-ready-drop UART.
// Optional UART_TX_FIFO_CRLF_EN expands each LF into CR then LF on the wire.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  state_t        state_reg, state_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_valid_reg, tx_valid_next;
  logic          overflow_reg;
  logic          full, empty, push, pop;
  logic [7:0]    head;
`ifdef UART_TX_FIFO_CRLF_EN
  logic          cr_sent_reg, cr_sent_next;
  logic          cr_turn;
`endif

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);
  // No pass-through: a full FIFO refuses writes even on a pop cycle.
  assign push  = bus.wr_valid && !full;
  assign head  = mem[rd_ptr_reg];

`ifdef UART_TX_FIFO_CRLF_EN
  // Head stays fixed until the pop, so the CR phase can be re-derived in ST_SEND.
  assign cr_turn = (head == 8'h0A) && !cr_sent_reg;
`endif

  always_comb begin
    state_next    = state_reg;
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    pop           = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_sent_next  = cr_sent_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (!empty && bus.tx_ready) begin
          tx_valid_next = 1'b1;
`ifdef UART_TX_FIFO_CRLF_EN
          tx_data_next  = cr_turn ? 8'h0D : head;
`else
          tx_data_next  = head;
`endif
          state_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = ST_WAIT;
`ifdef UART_TX_FIFO_CRLF_EN
          if (cr_turn) begin
            cr_sent_next = 1'b1;
          end else begin
            pop          = 1'b1;
            cr_sent_next = 1'b0;
          end
`else
          pop = 1'b1;
`endif
        end
      end
      ST_WAIT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      count_reg    <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (bus.wr_valid && full) begin
        overflow_reg <= 1'b1;
      end
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_reg  <= cr_sent_next;
`endif
    end
  end

  assign bus.wr_ready = !full;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.count    = count_reg;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_reg;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO plus drain sequencer between the board-rendering/control FSM and the UART transmitter. Producers push ASCII bytes (cell characters, CR/LF, ANSI escapes, banner text) with a valid/ready handshake in a single cycle. The drain side re-plays them to the transmitter using its raise-valid / wait-for-ready-drop protocol. The renderer no longer stalls per character, and its wait states collapse into one `wr_ready` check.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width. Derived; do not override.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  producer offers `wr_data` this cycle.
- `wr_data`  in  8  byte to enqueue.
- `wr_ready`  out  1  FIFO not full; a write is accepted when `wr_valid & wr_ready` at a rising edge.
- `tx_data`  out  8  byte presented to the transmitter's `in`.
- `tx_valid`  out  1  drives the transmitter's `valid`.
- `tx_ready`  in  1  transmitter's `ready`.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a write was attempted while full.

## Operation
- Storage is an 8-bit × DEPTH register array with `wr_ptr`/`rd_ptr` (AW bits) and registered `count`. Pointers wrap modulo DEPTH.
- `wr_ready = (count != DEPTH)`, decoded from registered state. A full FIFO never accepts a write, even in a cycle where a pop also occurs (no pass-through).
- Write while full: the data is dropped, pointers are unchanged, and `overflow <= 1`. `overflow` is cleared only by `reset`.
- The drain FSM uses two-bit state `ST_IDLE`, `ST_SEND`, `ST_WAIT`:
  - `ST_IDLE`: if `!empty && tx_ready`, then `tx_data <= mem[rd_ptr]` (or CR, see Configuration), `tx_valid <= 1`, and go to `ST_SEND`.
  - `ST_SEND`: hold `tx_valid = 1` until `tx_ready` is sampled low, meaning the transmitter latched the byte. Then `tx_valid <= 0`, pop (`rd_ptr++`, `count--`), and go to `ST_WAIT`.
  - `ST_WAIT`: one cycle, then go to `ST_IDLE`. This guarantees `tx_valid` is low for at least one cycle between bytes.
- `tx_data` is stable for as long as `tx_valid` is high.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- Reset (at any time, including mid-`ST_SEND`): state `ST_IDLE`, `tx_valid=0`, `tx_data=0x00`, pointers and `count` 0, `empty=1`, `wr_ready=1`, `overflow=0`. The in-flight byte is abandoned; if the transmitter already latched it, it still goes out.

## Timing
- Write accepted at edge N: `count`/`empty` update after edge N.
- Earliest `tx_valid` rise is after edge N+1, given `tx_ready=1`, so write-to-`tx_valid` latency is 2 edges.
- Pop occurs at the first edge in `ST_SEND` where `tx_ready==0`; `tx_valid` is low after that edge.
- Next byte: `tx_valid` rises no sooner than 2 edges after the previous pop (`ST_WAIT`, then `ST_IDLE`), and only once `tx_ready` is high again.
- Sustained rate is bounded by the UART (~2083 cycles/byte at 24 MHz / 115200); FIFO overhead is ≤ 3 cycles per byte.
- `wr_ready` falls after the edge that makes `count == DEPTH`, and rises after the edge that pops from full.

## Configuration
- Macro: `UART_TX_FIFO_CRLF_EN`.
- Defined:
  - When the head byte is 0x0A and the internal flag `cr_sent == 0`, `ST_IDLE` presents 0x0D instead.
  - Completing that transfer sets `cr_sent` and does not pop.
  - The next transfer sends 0x0A and pops, then clears `cr_sent`.
  - Reset clears `cr_sent`. Producers enqueue LF only.
- Undefined: bytes are sent verbatim and no `cr_sent` logic exists.

## Test plan
- Transmitter model with `ready` dropping 2 cycles after `valid` and returning 20 cycles later:
  - Single byte: write 0x4F at edge 10 → `tx_valid` high after edge 11, `tx_data=0x4F`. After the pop, `count=0` and `empty=1`.
  - Fill: write DEPTH+1 bytes 0x00..0x10 back-to-back while `tx_ready=0`.
    - → `wr_ready=0` after the 16th write, `count=16`, `overflow=1`.
    - Releasing `tx_ready` drains exactly 0x00..0x0F in order.
  - Wrap: 40 random bytes written over time with DEPTH=16.
    - → output sequence equals input.
    - `tx_valid` has ≥1 low cycle between bytes.
    - `tx_data` is stable while valid.
- Simultaneous write and pop at `count=5`: → `count` stays 5; both pointers advance by 1.
- Reset asserted while `tx_valid=1` with `count=3`: → after the reset edge `tx_valid=0`, `count=0`, `overflow=0`, `wr_ready=1`; no further bytes are sent.
- With `UART_TX_FIFO_CRLF_EN`: write 0x41, 0x0A → transmitted 0x41, 0x0D, 0x0A. Without the macro: → transmitted 0x41, 0x0A.
